// File: rtl/bypass_ctrl_pkg.sv
// Shared definitions for the operand bypass controller.
// Holds the one-hot bypass select encodings, the RUN/STALL state encodings,
// and the layout of one shadow-pipeline stage entry.
package bypass_ctrl_pkg;

  localparam int NUM_SRC = 2;   // source operand fields per instruction: rs, rt
  localparam int SEL_W   = 4;
  localparam int REG_W   = 5;

  localparam logic [SEL_W-1:0] SEL_RF  = 4'b0001;
  localparam logic [SEL_W-1:0] SEL_EXE = 4'b0010;
  localparam logic [SEL_W-1:0] SEL_MEM = 4'b0100;
  localparam logic [SEL_W-1:0] SEL_WB  = 4'b1000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // One in-flight writer as seen by the bypass network.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] waddr;
    logic             is_load;
  } stage_t;

endpackage

// File: rtl/bypass_ctrl_match.sv
// bypass_match: resolves one source register field against the three
// in-flight writers and produces a one-hot bypass select.
//   src      : source register number
//   exe/mem/wb: shadow pipeline entries, youngest first
//   sel      : one-hot select (SEL_RF / SEL_EXE / SEL_MEM / SEL_WB)
module bypass_match
  import bypass_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  stage_t           exe,
  input  stage_t           mem,
  input  stage_t           wb,
  output logic [SEL_W-1:0] sel
);

  // The load flag only matters for stall detection, not for source selection.
  logic unused_ld;
  assign unused_ld = exe.is_load ^ mem.is_load ^ wb.is_load;

  // $0 is hardwired to zero, so it never takes a bypass path.
  always_comb begin
    sel = SEL_RF;
    if (src != '0) begin
      if (exe.valid && exe.waddr == src)      sel = SEL_EXE;
      else if (mem.valid && mem.waddr == src) sel = SEL_MEM;
      else if (wb.valid && wb.waddr == src)   sel = SEL_WB;
    end
  end

endmodule

// File: rtl/bypass_ctrl.sv
// bypass_ctrl: operand bypass and load-use stall controller.
// Tracks the writers in EXE/MEM/WB with a shadow pipeline and drives the
// downstream bypass mux selects for rs and rt with zero latency.
//   clk, rst          : clock, asynchronous active-high reset
//   id_ins            : IF/ID instruction (rs = [25:21], rt = [20:16])
//   id_valid          : id_ins is a real instruction
//   id_uses_rs/rt     : ID instruction reads rs / rt
//   id_wreg_en/addr   : ID instruction writes register id_wreg_addr
//   id_is_load        : ID instruction is a load
//   flush             : squash the instruction leaving ID
//   rs_sel, rt_sel    : one-hot bypass selects
//   stall             : hold PC and IF/ID, bubble into EXE
//   stall_cnt         : saturating count of stall cycles
module bypass_ctrl
  import bypass_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_ins,
  input  logic             id_valid,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_wreg_en,
  input  logic [REG_W-1:0] id_wreg_addr,
  input  logic             id_is_load,
  input  logic             flush,
  output logic [SEL_W-1:0] rs_sel,
  output logic [SEL_W-1:0] rt_sel,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  logic unused_ins;
  assign unused_ins = ^{id_ins[31:26], id_ins[15:0]};

  logic [NUM_SRC-1:0][REG_W-1:0] src;
  logic [NUM_SRC-1:0]            src_used;
  logic [NUM_SRC-1:0][SEL_W-1:0] sel;

  assign src[0]      = id_ins[25:21];
  assign src[1]      = id_ins[20:16];
  assign src_used[0] = id_uses_rs;
  assign src_used[1] = id_uses_rt;

  stage_t exe_q, mem_q, wb_q, exe_d;
  state_t state_q, state_d;
  logic   load_use;

  // ---------------------------------------------------------------- selects
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    bypass_match u_match (
      .src (src[g]),
      .exe (exe_q),
      .mem (mem_q),
      .wb  (wb_q),
      .sel (sel[g])
    );
  end

  assign rs_sel = sel[0];
  assign rt_sel = sel[1];

  // ---------------------------------------------------------------- load-use
  // A load in EXE has no result yet; a dependent ID instruction must wait one
  // cycle so that the load reaches MEM and its data can be bypassed from there.
  always_comb begin
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      hit = hit | (src_used[i] & (src[i] == exe_q.waddr));
    load_use = id_valid & exe_q.valid & exe_q.is_load & (exe_q.waddr != '0) & hit;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (load_use && !flush) state_d = ST_STALL;
      ST_STALL: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // In STALL the bubble already occupies EXE, so a repeat stall is impossible;
  // gating on the state makes the one-cycle bound explicit. Flush wins.
  always_comb begin
    stall = (state_q == ST_RUN) & load_use & ~flush;
  end

  // ---------------------------------------------------------------- shadow pipe
  always_comb begin
    exe_d.valid   = id_valid & id_wreg_en & ~stall & ~flush;
    exe_d.waddr   = id_wreg_addr;
    exe_d.is_load = id_is_load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      exe_q <= exe_d;
      mem_q <= exe_q;
      wb_q  <= mem_q;
    end
  end

  // ---------------------------------------------------------------- statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule
